// File: rtl/blake2b_round_sched.sv
// BLAKE2b round scheduler: sequences one compression (init, 12 rounds of
// column/diagonal half-rounds over a shared 4-wide G array, finalize) and
// selects the eight message-word indices for each half-round.

package blake2b_pkg;

    // Message schedule permutation, ten rows of sixteen word indices.
    localparam logic [3:0] SIGMA [160] = '{
        4'd0,  4'd1,  4'd2,  4'd3,  4'd4,  4'd5,  4'd6,  4'd7,
        4'd8,  4'd9,  4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15,
        4'd14, 4'd10, 4'd4,  4'd8,  4'd9,  4'd15, 4'd13, 4'd6,
        4'd1,  4'd12, 4'd0,  4'd2,  4'd11, 4'd7,  4'd5,  4'd3,
        4'd11, 4'd8,  4'd12, 4'd0,  4'd5,  4'd2,  4'd15, 4'd13,
        4'd10, 4'd14, 4'd3,  4'd6,  4'd7,  4'd1,  4'd9,  4'd4,
        4'd7,  4'd9,  4'd3,  4'd1,  4'd13, 4'd12, 4'd11, 4'd14,
        4'd2,  4'd6,  4'd5,  4'd10, 4'd4,  4'd0,  4'd15, 4'd8,
        4'd9,  4'd0,  4'd5,  4'd7,  4'd2,  4'd4,  4'd10, 4'd15,
        4'd14, 4'd1,  4'd11, 4'd12, 4'd6,  4'd8,  4'd3,  4'd13,
        4'd2,  4'd12, 4'd6,  4'd10, 4'd0,  4'd11, 4'd8,  4'd3,
        4'd4,  4'd13, 4'd7,  4'd5,  4'd15, 4'd14, 4'd1,  4'd9,
        4'd12, 4'd5,  4'd1,  4'd15, 4'd14, 4'd13, 4'd4,  4'd10,
        4'd0,  4'd7,  4'd6,  4'd3,  4'd9,  4'd2,  4'd8,  4'd11,
        4'd13, 4'd11, 4'd7,  4'd14, 4'd12, 4'd1,  4'd3,  4'd9,
        4'd5,  4'd0,  4'd15, 4'd4,  4'd8,  4'd6,  4'd2,  4'd10,
        4'd6,  4'd15, 4'd14, 4'd9,  4'd11, 4'd3,  4'd0,  4'd8,
        4'd12, 4'd2,  4'd13, 4'd7,  4'd1,  4'd4,  4'd10, 4'd5,
        4'd10, 4'd2,  4'd8,  4'd4,  4'd7,  4'd6,  4'd1,  4'd5,
        4'd15, 4'd11, 4'd9,  4'd14, 4'd3,  4'd12, 4'd13, 4'd0
    };

endpackage

module blake2b_round_sched #(
    parameter int ROUNDS  = 12,
    parameter int TIMEOUT = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_blk_val,
    input  logic        i_blk_last,
    output logic        o_blk_rdy,
    input  logic        i_abort,
    output logic        o_init,
    output logic        o_g_val,
    output logic        o_g_diag,
    output logic [31:0] o_g_msg_idx,
    input  logic        i_g_val,
    output logic [3:0]  o_round,
    output logic        o_fin,
    output logic        o_done,
    output logic        o_done_last,
    output logic        o_err
);

    localparam int CNT_W = $clog2(TIMEOUT);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_INIT  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_FINAL = 3'd4;

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);
    // The counter starts at 0 in the first WAIT cycle; the cycle in which it
    // would step onto TIMEOUT-1 is the last chance for i_g_val.
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 2);

    logic [2:0]       state_reg, state_next;
    logic [3:0]       round_reg, round_next;
    logic             half_reg, half_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             last_reg, last_next;
    logic             err_reg, err_next;
    logic [31:0]      idx_reg, idx_next;
    logic [3:0]       row_next;
    logic [31:0]      idx_calc;

    // Next-state logic; abort overrides everything else while busy.
    always_comb begin
        state_next = state_reg;
        round_next = round_reg;
        half_next  = half_reg;
        cnt_next   = cnt_reg;
        last_next  = last_reg;
        err_next   = 1'b0;
        if (i_abort && (state_reg != ST_IDLE)) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_blk_val) begin
                        last_next  = i_blk_last;
                        state_next = ST_INIT;
                    end
                end
                ST_INIT: begin
                    round_next = 4'd0;
                    half_next  = 1'b0;
                    state_next = ST_ISSUE;
                end
                ST_ISSUE: begin
                    cnt_next   = '0;
                    state_next = ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_g_val) begin
                        if (!half_reg) begin
                            half_next  = 1'b1;
                            state_next = ST_ISSUE;
                        end else if (round_reg == LAST_ROUND) begin
                            state_next = ST_FINAL;
                        end else begin
                            half_next  = 1'b0;
                            round_next = round_reg + 4'd1;
                            state_next = ST_ISSUE;
                        end
                    end else if (cnt_reg == CNT_LIMIT) begin
                        err_next   = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                ST_FINAL: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
            // A G result nobody asked for is flagged but otherwise ignored.
            if (i_g_val && (state_reg != ST_WAIT)) begin
                err_next = 1'b1;
            end
        end
    end

    // SIGMA row is round mod 10; rounds never exceed 15, so one subtract suffices.
    always_comb begin
        row_next = (round_next >= 4'd10) ? (round_next - 4'd10) : round_next;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_idx
            assign idx_calc[gi*4 +: 4] = blake2b_pkg::SIGMA[{row_next, half_next, 3'(gi)}];
        end
    endgenerate

    // Indices are latched only on entry to ISSUE so they stay stable through WAIT.
    always_comb begin
        idx_next = (state_next == ST_ISSUE) ? idx_calc : idx_reg;
    end

    // State and counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= ST_IDLE;
            round_reg <= 4'd0;
            half_reg  <= 1'b0;
            cnt_reg   <= '0;
            last_reg  <= 1'b0;
            err_reg   <= 1'b0;
            idx_reg   <= 32'd0;
        end else begin
            state_reg <= state_next;
            round_reg <= round_next;
            half_reg  <= half_next;
            cnt_reg   <= cnt_next;
            last_reg  <= last_next;
            err_reg   <= err_next;
            idx_reg   <= idx_next;
        end
    end

    assign o_blk_rdy   = (state_reg == ST_IDLE);
    assign o_init      = (state_reg == ST_INIT);
    assign o_g_val     = (state_reg == ST_ISSUE);
    assign o_g_diag    = half_reg;
    assign o_g_msg_idx = idx_reg;
    assign o_round     = round_reg;
    assign o_fin       = (state_reg == ST_FINAL);
    assign o_done      = (state_reg == ST_FINAL);
    assign o_done_last = (state_reg == ST_FINAL) && last_reg;
    assign o_err       = err_reg;

endmodule

// File: tb/tb_blake2b_round_sched.sv
// Self-checking bench for blake2b_round_sched: table of block scenarios
// driven through a behavioural G-array responder, random-delay blocks
// checked against a schedule model, plus hand-written corner sequences.

module tb_blake2b_round_sched;

    localparam int ROUNDS = 12;
    localparam int NHALF  = 2 * ROUNDS;
    localparam int NCYC   = 260;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        blk_val = 1'b0;
    logic        blk_last = 1'b0;
    logic        abort = 1'b0;
    logic        g_val_in = 1'b0;
    logic        blk_rdy, init, g_val, g_diag, fin, done, done_last, err;
    logic [31:0] g_msg_idx;
    logic [3:0]  round;

    blake2b_round_sched #(.ROUNDS(ROUNDS), .TIMEOUT(64)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_blk_val   (blk_val),
        .i_blk_last  (blk_last),
        .o_blk_rdy   (blk_rdy),
        .i_abort     (abort),
        .o_init      (init),
        .o_g_val     (g_val),
        .o_g_diag    (g_diag),
        .o_g_msg_idx (g_msg_idx),
        .i_g_val     (g_val_in),
        .o_round     (round),
        .o_fin       (fin),
        .o_done      (done),
        .o_done_last (done_last),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    // Reference message permutation (BLAKE2 sigma, 10 rows).
    int sigma_tb [10][16] = '{
        '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
        '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
        '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
        '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
        '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
        '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
        '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
        '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
        '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
        '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}
    };

    typedef struct {
        string name;
        int    first_dly;
        int    dly;
        bit    last;
        int    abort_at;
        int    exp_issues;
        int    exp_done;
        bit    exp_done_last;
        int    exp_err;
        int    exp_fin;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    int          dly [NHALF];
    int          obs_issues, obs_done, obs_err, obs_err_cnt, obs_fin, obs_init_cnt, obs_abort_cyc;
    bit          obs_done_last;
    logic [31:0] obs_idx [NHALF];
    bit          rdy_hist [NCYC];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input string name, input int fd, input int d, input bit last,
                                input int ab, input int iss, input int dn, input bit dl,
                                input int er, input int fn);
        vec_t v;
        v.name = name; v.first_dly = fd; v.dly = d; v.last = last; v.abort_at = ab;
        v.exp_issues = iss; v.exp_done = dn; v.exp_done_last = dl; v.exp_err = er; v.exp_fin = fn;
        return v;
    endfunction

    // Expected packed indices for half-round n: element k from sigma row (round mod 10).
    function automatic logic [31:0] exp_idx(input int n);
        int r = n / 2;
        int h = n % 2;
        logic [31:0] v = 32'd0;
        for (int k = 0; k < 8; k++) v[4*k +: 4] = 4'(sigma_tb[r % 10][8*h + k]);
        return v;
    endfunction

    // Offer one block at cycle 0 and run a fixed window, acting as the G array
    // (answers dly[n] cycles after the n-th issue, never if dly[n]==0).
    task automatic run_block(input string name, input bit last, input int abort_at);
        int resp, exp_issue, hold_bad, fd_bad;
        bit have_hold;
        logic [3:0]  h_round;
        logic        h_diag;
        logic [31:0] h_idx;
        resp = -1; exp_issue = 2; hold_bad = 0; fd_bad = 0; have_hold = 0;
        h_round = 0; h_diag = 0; h_idx = 0;
        obs_issues = 0; obs_done = -1; obs_err = -1; obs_err_cnt = 0; obs_fin = 0;
        obs_init_cnt = 0; obs_abort_cyc = -1; obs_done_last = 0;
        check({name, " rdy_before"}, blk_rdy, 1);
        blk_val = 1'b1;
        blk_last = last;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            if (cyc > 0) begin
                blk_val = 1'b0;
                rdy_hist[cyc] = blk_rdy;
                if (cyc == 1) check({name, " init_cyc1"}, init, 1);
                if (init) obs_init_cnt++;
                if (g_val) begin
                    if (obs_issues < NHALF) begin
                        check($sformatf("%s issue%0d_cyc", name, obs_issues), cyc, exp_issue);
                        check($sformatf("%s issue%0d_round", name, obs_issues), round, obs_issues / 2);
                        check($sformatf("%s issue%0d_diag", name, obs_issues), g_diag, obs_issues % 2);
                        check($sformatf("%s issue%0d_idx", name, obs_issues), g_msg_idx, exp_idx(obs_issues));
                        obs_idx[obs_issues] = g_msg_idx;
                        resp = (dly[obs_issues] == 0) ? -1 : cyc + dly[obs_issues];
                        exp_issue = exp_issue + dly[obs_issues] + 1;
                    end
                    have_hold = 1; h_round = round; h_diag = g_diag; h_idx = g_msg_idx;
                    obs_issues++;
                end else if (have_hold && !blk_rdy) begin
                    if (round != h_round || g_diag != h_diag || g_msg_idx != h_idx) hold_bad++;
                end
                if (fin != done) fd_bad++;
                if (fin) obs_fin++;
                if (done && obs_done < 0) begin
                    obs_done = cyc;
                    obs_done_last = done_last;
                end
                if (err) begin
                    if (obs_err < 0) obs_err = cyc;
                    obs_err_cnt++;
                end
            end
            g_val_in = (cyc == resp);
            abort = (abort_at >= 0) && (obs_issues == abort_at + 1) && (cyc == resp);
            if (abort) obs_abort_cyc = cyc;
            step();
        end
        g_val_in = 1'b0;
        abort = 1'b0;
        check({name, " outputs_held"}, hold_bad, 0);
        check({name, " fin_with_done"}, fd_bad, 0);
        check({name, " init_pulses"}, obs_init_cnt, 1);
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = mk("blk_d4",     4,  4, 1'b1, -1, 24, 122, 1'b1, -1, 1);
        vecs[1] = mk("blk_d1_l0",  1,  1, 1'b0, -1, 24,  50, 1'b0, -1, 1);
        vecs[2] = mk("blk_d7",     7,  7, 1'b1, -1, 24, 194, 1'b1, -1, 1);
        vecs[3] = mk("gval_at_to", 63, 1, 1'b1, -1, 24, 112, 1'b1, -1, 1);
        vecs[4] = mk("timeout",    0,  0, 1'b0, -1,  1,  -1, 1'b0, 66, 0);
        vecs[5] = mk("abort_r5",   3,  3, 1'b1, 10, 11,  -1, 1'b0, -1, 0);

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst rdy", blk_rdy, 1);
        check("rst init", init, 0);
        check("rst g_val", g_val, 0);
        check("rst round", round, 0);
        check("rst idx", g_msg_idx, 0);
        check("rst done", done, 0);
        check("rst err", err, 0);
        rst_n = 1'b1;
        step();
        step();

        // Scenario table
        for (int v = 0; v < 6; v++) begin
            for (int n = 0; n < NHALF; n++) dly[n] = vecs[v].dly;
            dly[0] = vecs[v].first_dly;
            run_block(vecs[v].name, vecs[v].last, vecs[v].abort_at);
            check({vecs[v].name, " issues"}, obs_issues, vecs[v].exp_issues);
            check({vecs[v].name, " done_cyc"}, obs_done, vecs[v].exp_done);
            if (vecs[v].exp_done >= 0)
                check({vecs[v].name, " done_last"}, obs_done_last, vecs[v].exp_done_last);
            check({vecs[v].name, " err_cyc"}, obs_err, vecs[v].exp_err);
            check({vecs[v].name, " err_pulses"}, obs_err_cnt, (vecs[v].exp_err >= 0) ? 1 : 0);
            check({vecs[v].name, " fin_pulses"}, obs_fin, vecs[v].exp_fin);
            if (vecs[v].exp_err >= 0)
                check({vecs[v].name, " rdy_after_err"}, rdy_hist[vecs[v].exp_err], 1);
            if (vecs[v].abort_at >= 0) begin
                check({vecs[v].name, " abort_seen"}, (obs_abort_cyc > 0) ? 1 : 0, 1);
                if (obs_abort_cyc > 0 && obs_abort_cyc + 1 < NCYC) begin
                    check({vecs[v].name, " busy_at_abort"}, rdy_hist[obs_abort_cyc], 0);
                    check({vecs[v].name, " idle_after_abort"}, rdy_hist[obs_abort_cyc + 1], 1);
                end
            end
            if (v == 0) begin
                check("idx r0 col", obs_idx[0], 32'h76543210);
                check("idx r0 diag", obs_idx[1], 32'hFEDCBA98);
                check("idx r1 col", obs_idx[2], 32'h6DF984AE);
                check("idx r10 col", obs_idx[20], 32'h76543210);
            end
        end

        // Random per-half-round G delays against the schedule model
        for (int t = 0; t < 4; t++) begin
            int exp_done;
            bit lst;
            exp_done = 2;
            for (int n = 0; n < NHALF; n++) begin
                dly[n] = int'($urandom_range(1, 6));
                exp_done += dly[n] + 1;
            end
            lst = 1'($urandom_range(0, 1));
            run_block($sformatf("rand%0d", t), lst, -1);
            check($sformatf("rand%0d issues", t), obs_issues, NHALF);
            check($sformatf("rand%0d done_cyc", t), obs_done, exp_done);
            check($sformatf("rand%0d done_last", t), obs_done_last, lst);
            check($sformatf("rand%0d err", t), obs_err_cnt, 0);
        end

        // Spurious G result while idle
        g_val_in = 1'b1;
        step();
        g_val_in = 1'b0;
        check("spur err", err, 1);
        check("spur rdy", blk_rdy, 1);
        step();
        check("spur err_clear", err, 0);
        check("spur rdy_stay", blk_rdy, 1);

        // Back-to-back blocks with blk_val held high, G delay 1
        begin
            int resp, ndone;
            int dc [2];
            bit dl [2];
            resp = -1; ndone = 0; dc[0] = -1; dc[1] = -1; dl[0] = 1; dl[1] = 0;
            blk_val = 1'b1;
            blk_last = 1'b0;
            for (int cyc = 0; cyc < 140; cyc++) begin
                if (cyc > 0) begin
                    if (cyc == 1) blk_last = 1'b1;
                    if (init && cyc > 1) blk_val = 1'b0;
                    if (g_val) resp = cyc + 1;
                    if (done) begin
                        if (ndone < 2) begin
                            dc[ndone] = cyc;
                            dl[ndone] = done_last;
                        end
                        ndone++;
                    end
                end
                g_val_in = (cyc == resp);
                step();
            end
            blk_val = 1'b0;
            g_val_in = 1'b0;
            check("b2b done_count", ndone, 2);
            check("b2b done0_cyc", dc[0], 50);
            check("b2b done0_last", dl[0], 0);
            check("b2b done1_cyc", dc[1], 101);
            check("b2b done1_last", dl[1], 1);
        end

        // Asynchronous reset mid-compression
        begin
            bit pv;
            pv = 1'b0;
            blk_val = 1'b1;
            blk_last = 1'b1;
            step();
            blk_val = 1'b0;
            for (int c = 1; c <= 12; c++) begin
                g_val_in = pv;
                pv = g_val;
                step();
            end
            g_val_in = 1'b0;
            check("arst pre_round", round, 2);
            check("arst pre_diag", g_diag, 1);
            check("arst pre_busy", blk_rdy, 0);
            #2;
            rst_n = 1'b0;
            #1;
            check("arst rdy", blk_rdy, 1);
            check("arst round", round, 0);
            check("arst diag", g_diag, 0);
            check("arst idx", g_msg_idx, 0);
            #2;
            rst_n = 1'b1;
            step();
            check("arst stay_idle", blk_rdy, 1);
            check("arst no_init", init, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
